esm_issue_buffer: RTL and testbench

ESM_ISSUE_BUFFER -- requirements
Module: esm_issue_buffer

---
 rtl/esm_pkg.sv | 18 +
 rtl/esm_rank_select.sv | 34 +++
 rtl/esm_issue_buffer.sv | 183 ++++++++++++++++++
 tb/tb_esm_issue_buffer.sv | 454 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/esm_pkg.sv
// Shared types and constants for the ESM issue buffer.
package esm_pkg;

    localparam int ESM_DEF_BS = 16;
    localparam int ESM_DEF_DW = 32;

    typedef enum logic [1:0] {
        ST_FILL  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2
    } esm_state_e;

    // Width of a slot index for an n-slot buffer (at least one bit).
    function automatic int esm_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/esm_rank_select.sv
// Combinational k-th set bit finder: returns the one-hot and the index of the
// k-th occupied entry of mask_i, counting from bit 0.
module esm_rank_select
    import esm_pkg::*;
#(
    parameter  int BS = ESM_DEF_BS,
    localparam int IW = esm_idx_w(BS)
) (
    input  logic [BS-1:0] mask_i,
    input  logic [IW-1:0] k_i,
    output logic [BS-1:0] onehot_o,
    output logic [IW-1:0] idx_o,
    output logic          found_o
);

    always_comb begin
        logic [IW:0] seen;
        onehot_o = '0;
        idx_o    = '0;
        found_o  = 1'b0;
        seen     = '0;
        for (int i = 0; i < BS; i++) begin
            if (mask_i[i]) begin
                if (!found_o && (seen == {1'b0, k_i})) begin
                    onehot_o[i] = 1'b1;
                    idx_o       = IW'(i);
                    found_o     = 1'b1;
                end
                seen = seen + (IW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/esm_issue_buffer.sv
// Randomised-order instruction issue buffer feeding an ESM core.
// Optional build macro ESM_SHUFFLE_BYPASS_EN adds shuffle_en for in-order issue.
module esm_issue_buffer
    import esm_pkg::*;
#(
    parameter  int BS       = ESM_DEF_BS,
    parameter  int DW       = ESM_DEF_DW,
    parameter  int MIN_FILL = 4,
    localparam int IW       = esm_idx_w(BS),
    localparam int CW       = IW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    input  logic          sel_valid,
    output logic          sel_ready,
    input  logic [IW-1:0] sel_rank,
    input  logic          flush,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic [BS-1:0] occ_mask,
    output logic [CW-1:0] occ_count
`ifdef ESM_SHUFFLE_BYPASS_EN
    ,
    input  logic          shuffle_en
`endif
);

    if ((BS & (BS - 1)) != 0 || BS < 4 || BS > 64) begin : g_bad_bs
        $error("esm_issue_buffer: BS must be a power of two in 4..64");
    end
    if (MIN_FILL < 1 || MIN_FILL > BS) begin : g_bad_min_fill
        $error("esm_issue_buffer: MIN_FILL must be in 1..BS");
    end

    localparam logic [CW-1:0] BS_C       = CW'(BS);
    localparam logic [CW-1:0] MIN_FILL_C = CW'(MIN_FILL);

    esm_state_e    state_q, state_d;
    logic [BS-1:0] mask_q, mask_d;
    logic [DW-1:0] slot_q [BS];
    logic          out_valid_q, out_valid_d;
    logic [DW-1:0] out_data_q, out_data_d;

    logic [CW-1:0] count;
    logic [CW-1:0] count_d;
    logic [CW-1:0] divisor;
    logic [CW-1:0] rank_mod;
    logic [IW-1:0] k;
    logic          rank_ok;
    logic          eligible;
    logic          issue_fire;
    logic          ins_fire;

    logic [BS-1:0] pick_onehot;
    logic [IW-1:0] pick_idx;
    logic          pick_found;
    logic [BS-1:0] free_onehot;
    logic [IW-1:0] free_idx;
    logic          free_found;

    always_comb begin
        count = '0;
        for (int i = 0; i < BS; i++) begin
            count = count + CW'(mask_q[i]);
        end
    end

    // Divisor forced to 1 when empty; issue is blocked then anyway.
    assign divisor  = (count == '0) ? CW'(1) : count;
    assign rank_mod = {1'b0, sel_rank} % divisor;

`ifdef ESM_SHUFFLE_BYPASS_EN
    assign rank_ok   = shuffle_en ? sel_valid : 1'b1;
    assign k         = shuffle_en ? IW'(rank_mod) : '0;
    assign sel_ready = issue_fire && shuffle_en;
`else
    assign rank_ok   = sel_valid;
    assign k         = IW'(rank_mod);
    assign sel_ready = issue_fire;
`endif

    esm_rank_select #(.BS(BS)) u_pick (
        .mask_i   (mask_q),
        .k_i      (k),
        .onehot_o (pick_onehot),
        .idx_o    (pick_idx),
        .found_o  (pick_found)
    );

    // Lowest free slot is the 0th set bit of the inverted pre-issue mask,
    // so a slot emptied by this cycle's issue cannot be refilled until next cycle.
    esm_rank_select #(.BS(BS)) u_free (
        .mask_i   (~mask_q),
        .k_i      ('0),
        .onehot_o (free_onehot),
        .idx_o    (free_idx),
        .found_o  (free_found)
    );

    assign eligible   = (state_q == ST_ISSUE) || (state_q == ST_DRAIN);
    assign issue_fire = rank_ok && (count != '0) && eligible && pick_found
                        && (!out_valid_q || out_ready);
    assign in_ready   = !rst && (count < BS_C) && (state_q != ST_DRAIN);
    assign ins_fire   = in_valid && in_ready && free_found;

    always_comb begin
        mask_d = mask_q;
        if (issue_fire) begin
            mask_d = mask_d & ~pick_onehot;
        end
        if (ins_fire) begin
            mask_d = mask_d | free_onehot;
        end
    end

    assign count_d = count + CW'(ins_fire) - CW'(issue_fire);

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        if (issue_fire) begin
            out_valid_d = 1'b1;
            out_data_d  = slot_q[pick_idx];
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_FILL: begin
                if (count >= MIN_FILL_C) begin
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (count_d < MIN_FILL_C) begin
                    state_d = ST_FILL;
                end
            end
            ST_DRAIN: begin
                if ((count == '0) && !out_valid_q) begin
                    state_d = ST_FILL;
                end
            end
            default: state_d = ST_FILL;
        endcase
        if (flush) begin
            state_d = ST_DRAIN;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_FILL;
            mask_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            mask_q      <= mask_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    always_ff @(posedge clk) begin
        if (ins_fire) begin
            slot_q[free_idx] <= in_data;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign occ_mask  = mask_q;
    assign occ_count = count;

endmodule

// File: tb/tb_esm_issue_buffer.sv
// Scoreboard bench for esm_issue_buffer (default parameters).
module tb_esm_issue_buffer;

    localparam int BS = 16;
    localparam int DW = 32;
    localparam int IW = 4;
    localparam int CW = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic          sel_valid = 1'b0;
    logic          sel_ready;
    logic [IW-1:0] sel_rank = '0;
    logic          flush = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [DW-1:0] out_data;
    logic [BS-1:0] occ_mask;
    logic [CW-1:0] occ_count;
`ifdef ESM_SHUFFLE_BYPASS_EN
    logic          shuffle_en = 1'b1;
`endif

    int checks = 0;
    int passes = 0;

    logic [DW-1:0] exp_q[$];
    logic [BS-1:0] m_mask;
    logic [DW-1:0] m_data [BS];

    always #5 clk = ~clk;

    esm_issue_buffer dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .sel_valid (sel_valid),
        .sel_ready (sel_ready),
        .sel_rank  (sel_rank),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .occ_mask  (occ_mask),
        .occ_count (occ_count)
`ifdef ESM_SHUFFLE_BYPASS_EN
        ,
        .shuffle_en(shuffle_en)
`endif
    );

    function automatic int m_count();
        int c = 0;
        for (int i = 0; i < BS; i++) if (m_mask[i]) c++;
        return c;
    endfunction

    function automatic int m_kth(input int k);
        int seen = 0;
        for (int i = 0; i < BS; i++) begin
            if (m_mask[i]) begin
                if (seen == k) return i;
                seen++;
            end
        end
        return -1;
    endfunction

    // Reference update for one cycle: issue from, and insert into, the pre-cycle mask.
    task automatic m_step(input bit ins, input logic [DW-1:0] d, input bit iss, input int k);
        logic [BS-1:0] pre;
        int s;
        pre = m_mask;
        if (iss) begin
            s = m_kth(k);
            if (s >= 0) begin
                exp_q.push_back(m_data[s]);
                m_mask[s] = 1'b0;
            end
        end
        if (ins) begin
            for (int i = 0; i < BS; i++) begin
                if (!pre[i]) begin
                    m_data[i] = d;
                    m_mask[i] = 1'b1;
                    break;
                end
            end
        end
    endtask

    // Advance one clock; output handshakes are scored at the falling edge.
    task automatic tick();
        logic [DW-1:0] e;
        @(negedge clk);
        if (!rst && out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL sb_unexpected: out_data=%h issued, required no output", out_data);
            end else begin
                e = exp_q.pop_front();
                if (out_data !== e) $display("FAIL sb_data: out_data=%h required %h", out_data, e);
                else passes++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain_all();
        int guard;
        in_valid = 1'b0; sel_valid = 1'b0; out_ready = 1'b1; flush = 1'b1;
        tick();
        flush = 1'b0;
        guard = 0;
        while (m_count() > 0 && guard < BS + 4) begin
            sel_valid = 1'b1;
            sel_rank = IW'($urandom_range(0, BS - 1));
            #1;
            checks++;
            if (sel_ready !== 1'b1) $display("FAIL drain_sel_ready: got %b required 1", sel_ready);
            else passes++;
            m_step(1'b0, '0, 1'b1, int'(sel_rank) % m_count());
            tick();
            guard++;
        end
        sel_valid = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b0) $display("FAIL drain_in_ready: got %b required 0", in_ready);
        else passes++;
        tick();
        checks++;
        if (out_valid !== 1'b0) $display("FAIL drain_out_valid: got %b required 0", out_valid);
        else passes++;
        tick();
        checks++;
        if (in_ready !== 1'b1 || occ_count !== 5'd0)
            $display("FAIL drain_done: in_ready=%b occ_count=%0d required 1 and 0", in_ready, occ_count);
        else passes++;
        checks++;
        if (exp_q.size() != 0) $display("FAIL drain_sb_left: %0d entries pending, required 0", exp_q.size());
        else passes++;
    endtask

    task automatic test_reset();
        sel_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b0 || sel_ready !== 1'b0)
            $display("FAIL reset_ready: in_ready=%b sel_ready=%b required 0 0", in_ready, sel_ready);
        else passes++;
        checks++;
        if (occ_mask !== '0 || occ_count !== '0 || out_valid !== 1'b0 || out_data !== '0)
            $display("FAIL reset_state: mask=%h count=%0d ov=%b od=%h required all 0",
                     occ_mask, occ_count, out_valid, out_data);
        else passes++;
        rst = 1'b0;
        sel_valid = 1'b0;
        m_mask = '0;
        exp_q.delete();
        #1;
        checks++;
        if (in_ready !== 1'b1) $display("FAIL reset_release_in_ready: got %b required 1", in_ready);
        else passes++;
        tick();
    endtask

    task automatic test_rank_select();
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_data = 32'hA0 + i;
            #1;
            checks++;
            if (in_ready !== 1'b1) $display("FAIL rank_ins_ready[%0d]: got %b required 1", i, in_ready);
            else passes++;
            m_step(1'b1, in_data, 1'b0, 0);
            tick();
        end
        in_valid = 1'b0; sel_valid = 1'b1; sel_rank = 4'd6;
        #1;
        checks++;
        if (sel_ready !== 1'b0 || occ_count !== 5'd4)
            $display("FAIL rank_fill_wait: sel_ready=%b count=%0d required 0 4", sel_ready, occ_count);
        else passes++;
        tick();
        checks++;
        if (sel_ready !== 1'b1) $display("FAIL rank_issue_ready: got %b required 1", sel_ready);
        else passes++;
        m_step(1'b0, '0, 1'b1, 6 % m_count());
        tick();
        sel_rank = 4'd0;
        #1;
        checks++;
        if (occ_mask !== 16'h000B || occ_count !== 5'd3)
            $display("FAIL rank_mask: mask=%h count=%0d required 000b 3", occ_mask, occ_count);
        else passes++;
        checks++;
        if (out_valid !== 1'b1 || out_data !== 32'hA2)
            $display("FAIL rank_out: ov=%b od=%h required 1 000000a2", out_valid, out_data);
        else passes++;
        checks++;
        if (sel_ready !== 1'b0) $display("FAIL rank_back_to_fill: sel_ready=%b required 0", sel_ready);
        else passes++;
        sel_valid = 1'b0;
        tick();
        drain_all();
    endtask

    task automatic test_full();
        int r;
        for (int i = 0; i < BS; i++) begin
            in_valid = 1'b1; in_data = 32'hC0 + i;
            #1;
            checks++;
            if (in_ready !== 1'b1) $display("FAIL full_ins_ready[%0d]: got %b required 1", i, in_ready);
            else passes++;
            m_step(1'b1, in_data, 1'b0, 0);
            tick();
        end
        for (int i = 0; i < 2; i++) begin
            in_data = 32'hDEAD_0000 + i;
            #1;
            checks++;
            if (in_ready !== 1'b0) $display("FAIL full_in_ready[%0d]: got %b required 0", i, in_ready);
            else passes++;
            tick();
        end
        checks++;
        if (occ_count !== 5'd16 || occ_mask !== 16'hFFFF)
            $display("FAIL full_state: count=%0d mask=%h required 16 ffff", occ_count, occ_mask);
        else passes++;
        r = $urandom_range(0, BS - 1);
        sel_valid = 1'b1; sel_rank = IW'(r);
        #1;
        checks++;
        if (sel_ready !== 1'b1) $display("FAIL full_sel_ready: got %b required 1", sel_ready);
        else passes++;
        m_step(1'b0, '0, 1'b1, r);
        tick();
        in_valid = 1'b0; sel_valid = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1 || occ_count !== 5'd15 || occ_mask !== ~(16'h1 << r))
            $display("FAIL full_after_issue: in_ready=%b count=%0d mask=%h required 1 15 slot %0d clear",
                     in_ready, occ_count, occ_mask, r);
        else passes++;
        drain_all();
    endtask

    task automatic test_flush();
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1; in_data = 32'hB0 + i;
            m_step(1'b1, in_data, 1'b0, 0);
            tick();
        end
        in_valid = 1'b0; flush = 1'b1; sel_valid = 1'b1; out_ready = 1'b1;
        #1;
        checks++;
        if (sel_ready !== 1'b0) $display("FAIL flush_fill_sel: got %b required 0", sel_ready);
        else passes++;
        tick();
        flush = 1'b0;
        for (int i = 0; i < 2; i++) begin
            sel_rank = IW'($urandom_range(0, BS - 1));
            #1;
            checks++;
            if (sel_ready !== 1'b1 || in_ready !== 1'b0)
                $display("FAIL flush_drain[%0d]: sel_ready=%b in_ready=%b required 1 0", i, sel_ready, in_ready);
            else passes++;
            m_step(1'b0, '0, 1'b1, int'(sel_rank) % m_count());
            tick();
        end
        sel_valid = 1'b0;
        tick();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0)
            $display("FAIL flush_last: ov=%b in_ready=%b required 0 0", out_valid, in_ready);
        else passes++;
        tick();
        checks++;
        if (in_ready !== 1'b1) $display("FAIL flush_to_fill: in_ready=%b required 1", in_ready);
        else passes++;
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_data = 32'hD0 + i;
            m_step(1'b1, in_data, 1'b0, 0);
            tick();
        end
        in_valid = 1'b0; sel_valid = 1'b1; sel_rank = 4'd3; out_ready = 1'b0;
        #1;
        checks++;
        if (sel_ready !== 1'b1) $display("FAIL bp_first_issue: got %b required 1", sel_ready);
        else passes++;
        m_step(1'b0, '0, 1'b1, 3 % m_count());
        tick();
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== 32'hD3)
                $display("FAIL bp_hold[%0d]: ov=%b od=%h required 1 000000d3", i, out_valid, out_data);
            else passes++;
            checks++;
            if (sel_ready !== 1'b0 || occ_count !== 5'd4)
                $display("FAIL bp_stall[%0d]: sel_ready=%b count=%0d required 0 4", i, sel_ready, occ_count);
            else passes++;
            tick();
        end
        out_ready = 1'b1; sel_valid = 1'b0;
        tick();
        drain_all();
    endtask

    task automatic test_simultaneous();
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_data = 32'hE0 + i;
            m_step(1'b1, in_data, 1'b0, 0);
            tick();
        end
        in_valid = 1'b0;
        tick();
        in_valid = 1'b1; in_data = 32'hE4; sel_valid = 1'b1; sel_rank = 4'd0;
        #1;
        checks++;
        if (in_ready !== 1'b1 || sel_ready !== 1'b1)
            $display("FAIL simul_ready: in_ready=%b sel_ready=%b required 1 1", in_ready, sel_ready);
        else passes++;
        m_step(1'b1, in_data, 1'b1, 0);
        tick();
        sel_valid = 1'b0; in_data = 32'hE5;
        #1;
        checks++;
        if (occ_mask !== 16'h001E || occ_count !== 5'd4)
            $display("FAIL simul_mask: mask=%h count=%0d required 001e 4", occ_mask, occ_count);
        else passes++;
        m_step(1'b1, in_data, 1'b0, 0);
        tick();
        in_valid = 1'b0;
        #1;
        checks++;
        if (occ_mask !== 16'h001F) $display("FAIL simul_reuse: mask=%h required 001f", occ_mask);
        else passes++;
        drain_all();
    endtask

`ifdef ESM_SHUFFLE_BYPASS_EN
    task automatic test_bypass();
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_data = 32'h10 + i;
            m_step(1'b1, in_data, 1'b0, 0);
            tick();
        end
        in_valid = 1'b0; flush = 1'b1;
        tick();
        flush = 1'b0; sel_valid = 1'b1; sel_rank = 4'd0;
        m_step(1'b0, '0, 1'b1, 0);
        tick();
        sel_rank = 4'd1;
        m_step(1'b0, '0, 1'b1, 1);
        tick();
        sel_valid = 1'b0;
        #1;
        checks++;
        if (occ_mask !== 16'h000A) $display("FAIL byp_setup: mask=%h required 000a", occ_mask);
        else passes++;
        shuffle_en = 1'b0;
        m_step(1'b0, '0, 1'b1, 0);
        tick();
        shuffle_en = 1'b1;
        #1;
        checks++;
        if (occ_mask !== 16'h0008 || out_data !== 32'h11)
            $display("FAIL byp_slot1: mask=%h od=%h required 0008 00000011", occ_mask, out_data);
        else passes++;
        sel_valid = 1'b1;
        m_step(1'b0, '0, 1'b1, 0);
        tick();
        sel_valid = 1'b0;
        tick();
        tick();
        checks++;
        if (in_ready !== 1'b1 || occ_count !== 5'd0)
            $display("FAIL byp_done: in_ready=%b count=%0d required 1 0", in_ready, occ_count);
        else passes++;
    endtask
`endif

    task automatic test_reset_mid();
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; in_data = 32'hF0 + i;
            m_step(1'b1, in_data, 1'b0, 0);
            tick();
        end
        in_valid = 1'b0; sel_valid = 1'b1; sel_rank = 4'd0; out_ready = 1'b0;
        #1;
        checks++;
        if (sel_ready !== 1'b1) $display("FAIL rstmid_issue: got %b required 1", sel_ready);
        else passes++;
        m_step(1'b0, '0, 1'b1, 0);
        tick();
        sel_valid = 1'b0;
        #1;
        checks++;
        if (occ_count !== 5'd7 || out_valid !== 1'b1)
            $display("FAIL rstmid_pre: count=%0d ov=%b required 7 1", occ_count, out_valid);
        else passes++;
        rst = 1'b1;
        #1;
        checks++;
        if (occ_mask !== '0 || occ_count !== '0 || out_valid !== 1'b0 || in_ready !== 1'b0)
            $display("FAIL rstmid_async: mask=%h count=%0d ov=%b in_ready=%b required 0 0 0 0",
                     occ_mask, occ_count, out_valid, in_ready);
        else passes++;
        exp_q.delete();
        m_mask = '0;
        tick();
        rst = 1'b0; out_ready = 1'b1; sel_valid = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1 || sel_ready !== 1'b0)
            $display("FAIL rstmid_after: in_ready=%b sel_ready=%b required 1 0", in_ready, sel_ready);
        else passes++;
        sel_valid = 1'b0;
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, required bench completion");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_rank_select();
        test_full();
        test_flush();
        test_backpressure();
        test_simultaneous();
`ifdef ESM_SHUFFLE_BYPASS_EN
        test_bypass();
`endif
        test_reset_mid();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
